// File: rtl/alu_pkg.sv
// Shared constants, operation/state encodings and the single-cycle ALU function
// for the RV32I execute unit. The ALU control decoder imports alu_ctl_e from here.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int SHW  = $clog2(XLEN);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_ctl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] ctl);
    return (ctl == ALU_SLL) || (ctl == ALU_SRL) || (ctl == ALU_SRA);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] ctl);
    return ctl <= 4'd9;
  endfunction

  // Non-shift operations; shift and unassigned codes yield zero here.
  function automatic logic [XLEN-1:0] alu_logic(input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b,
                                                 input logic [3:0]      ctl);
    logic [XLEN-1:0] r;
    case (alu_ctl_e'(ctl))
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_unit_shifter.sv
// Shifter for alu_exec_unit: serial 1 bit/cycle engine by default, or a
// combinational barrel shifter when ALU_BARREL_SHIFT_EN is defined.
`ifdef ALU_BARREL_SHIFT_EN
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] data_i,
  input  logic [SHW-1:0]  shamt_i,
  input  logic [3:0]      ctl_i,
  output logic [XLEN-1:0] data_o
);

  // Single-cycle shift of any amount.
  always_comb begin
    data_o = data_i;
    case (alu_ctl_e'(ctl_i))
      ALU_SLL: data_o = data_i << shamt_i;
      ALU_SRL: data_o = data_i >> shamt_i;
      ALU_SRA: data_o = $unsigned($signed(data_i) >>> shamt_i);
      default: data_o = data_i;
    endcase
  end

endmodule
`else
module alu_shifter
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [SHW-1:0]  shamt_i,
  input  logic [3:0]      ctl_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] next_o
);

  logic [XLEN-1:0] work_q;
  logic [XLEN-1:0] work_d;
  logic [SHW-1:0]  cnt_q;
  logic            left_q;
  logic            arith_q;

  // One-bit step of the working register in the captured direction.
  always_comb begin
    if (left_q) begin
      work_d = {work_q[XLEN-2:0], 1'b0};
    end else begin
      work_d = {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]};
    end
  end

  // Working register and remaining-step counter; reset abandons any shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q  <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load_i) begin
      work_q  <= data_i;
      cnt_q   <= shamt_i;
      left_q  <= (ctl_i == ALU_SLL);
      arith_q <= (ctl_i == ALU_SRA);
    end else if (step_i && (cnt_q != '0)) begin
      work_q <= work_d;
      cnt_q  <= cnt_q - SHW'(1);
    end
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = step_i && (cnt_q == SHW'(1));
  assign next_o = work_d;

endmodule
`endif

// File: rtl/alu_exec_unit.sv
// RV32I execute-stage ALU with valid/ready on both sides. Shifts are serial
// unless ALU_BARREL_SHIFT_EN is defined, which makes every op single-cycle.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic            accept_s;
  logic            shift_start_s;
  logic [XLEN-1:0] new_result_s;
  logic            new_zero_s;
  logic            new_illegal_s;
  alu_state_e      new_state_s;

  assign in_ready  = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);

`ifdef ALU_BARREL_SHIFT_EN
  logic [XLEN-1:0] shift_out_s;

  alu_shifter u_shifter (
    .data_i  (op_a),
    .shamt_i (op_b[SHW-1:0]),
    .ctl_i   (alu_ctl),
    .data_o  (shift_out_s)
  );

  assign shift_start_s = 1'b0;
  assign new_result_s  = is_shift_op(alu_ctl) ? shift_out_s : alu_logic(op_a, op_b, alu_ctl);
`else
  logic            shift_load_s;
  logic            shift_step_s;
  logic            shift_busy_s;
  logic            shift_done_s;
  logic [XLEN-1:0] shift_out_s;

  // A zero shift amount needs no stepping: the result is op_a itself.
  assign shift_start_s = is_shift_op(alu_ctl) && (op_b[SHW-1:0] != '0);
  assign shift_load_s  = accept_s && shift_start_s;
  assign shift_step_s  = (state_q == ST_SHIFT);
  assign new_result_s  = is_shift_op(alu_ctl) ? op_a : alu_logic(op_a, op_b, alu_ctl);

  alu_shifter u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (shift_load_s),
    .step_i  (shift_step_s),
    .data_i  (op_a),
    .shamt_i (op_b[SHW-1:0]),
    .ctl_i   (alu_ctl),
    .busy_o  (shift_busy_s),
    .done_o  (shift_done_s),
    .next_o  (shift_out_s)
  );
`endif

  assign new_zero_s    = (new_result_s == '0);
  assign new_illegal_s = !is_legal_op(alu_ctl);
  assign new_state_s   = shift_start_s ? ST_SHIFT : ST_DONE;

  // Next state and result capture; held outputs only change on accept or shift completion.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d   = new_state_s;
          result_d  = new_result_s;
          zero_d    = new_zero_s;
          illegal_d = new_illegal_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
`ifdef ALU_BARREL_SHIFT_EN
        state_d = ST_IDLE;
`else
        if (shift_done_s) begin
          state_d   = ST_DONE;
          result_d  = shift_out_s;
          zero_d    = (shift_out_s == '0);
          illegal_d = 1'b0;
        end else if (!shift_busy_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
`endif
      end
      ST_DONE: begin
        if (accept_s) begin
          state_d   = new_state_s;
          result_d  = new_result_s;
          zero_d    = new_zero_s;
          illegal_d = new_illegal_s;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- RV32I execute-stage ALU, directly downstream of the ALU control decoder: consumes the 4-bit ALU control code plus two operands and produces the result.
- Logic and arithmetic ops complete in one cycle. Shifts run on a serial 1-bit/cycle shifter by default.
- Valid/ready handshake on both sides, so the pipeline stalls cleanly while a shift is in progress.

Parameters:
- XLEN, 32, operand/result width.
- SHW, $clog2(XLEN) = 5, shift-amount width; derived, not overridable.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and control code are valid.
- in_ready  out  1  unit can accept a new operation.
- alu_ctl  in  4  operation code from the ALU control decoder.
- op_a  in  XLEN  rs1 value.
- op_b  in  XLEN  rs2 value or sign-extended immediate.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- result  out  XLEN  operation result.
- zero  out  1  result == 0; for branch compare.
- illegal  out  1  alu_ctl was an unassigned code.

Behaviour:
- Reset is asynchronous, active-low. While rst_n = 0: state = IDLE, in_ready = 0, out_valid = 0, result = 0, zero = 0, illegal = 0, shift counter = 0.
- in_ready = 1 in IDLE. It is also 1 in DONE when out_ready = 1, which allows back-to-back issue. It is 0 in SHIFT.
- An operation is accepted on a rising edge where in_valid && in_ready. op_a, op_b and alu_ctl are captured on that edge.
- States:
  - IDLE: on accept of a non-shift op, or a shift with shamt = 0, go to DONE. On accept of a shift with shamt != 0, go to SHIFT.
  - SHIFT: shift the working register 1 bit per cycle and decrement the counter. When the counter reaches 1, go to DONE on the next edge.
  - DONE: out_valid = 1. On out_ready, go to IDLE, or, if a new accept happens on the same edge, go directly to DONE or SHIFT for the new op.
- Latency, for accept at edge N:
  - Non-shift op: out_valid at N+1.
  - Shift by k (k = op_b[4:0]): out_valid at N+1+k, k = 0..31.
- alu_ctl encoding:
  - 0 ADD: a+b, modulo 2^XLEN.
  - 1 SUB: a-b, modulo 2^XLEN.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLT: signed compare, result 0 or 1.
  - 6 SLTU: unsigned compare, result 0 or 1.
  - 7 SLL.
  - 8 SRL: zero fill.
  - 9 SRA: sign fill.
  - 10-15: result = 0, illegal = 1, one-cycle latency.
- Only op_b[SHW-1:0] is used as shamt; upper bits are ignored.
- Output stability: result, zero and illegal are held stable while out_valid && !out_ready. Never change an unaccepted result.
- zero and illegal are registered together with result.
- Reset mid-shift: the operation is abandoned and no output is produced.
- in_valid may toggle freely while in_ready = 0; no capture happens.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter. SHIFT state and counter are removed. All ops, including shifts of any amount, reach out_valid at N+1, and in_ready is never low due to a shift.
- Undefined: serial shifter as described above; smaller area, variable latency.

Decomposition:
- Shared package alu_pkg holds:
  - XLEN and SHW constants.
  - alu_ctl_e enum (ALU_ADD=0 ... ALU_SRA=9). The ALU control decoder must import the same enum so encodings cannot diverge.
  - State enum (IDLE, SHIFT, DONE).
- One natural sub-module: alu_shifter.
  - Serial version: load/step/busy/done interface.
  - Barrel version: selected by the macro.
- The arithmetic/logic datapath stays inline.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001: result 0x80000000, zero = 0, out_valid one cycle after accept. ADD 0xFFFFFFFF + 1: result 0, zero = 1.
- SLT a = 0xFFFFFFFF, b = 1: result 1. SLTU with the same operands: result 0. SUB 5-5: result 0, zero = 1.
- SRA 0x80000000 by 31 (serial): in_ready low for 31 cycles, out_valid at N+32, result 0xFFFFFFFF. SRL same operands: result 0x00000001. With ALU_BARREL_SHIFT_EN defined: out_valid at N+1.
- Shift with op_b = 0x00000020 (shamt = 0): result = op_a, latency 1. alu_ctl = 12: result 0, illegal = 1.
- Backpressure: hold out_ready = 0 for 5 cycles after an XOR result. result is stable and in_ready = 0. Then assert out_ready together with a new in_valid: the new op is accepted on the same edge and its result appears the next cycle.
- Assert rst_n = 0 mid-SLL by 20 at cycle 7: outputs return to reset values immediately. After release, in_ready = 1 and no stale out_valid appears.
